id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/imm_gen.sv | 24 ++
 rtl/id_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate format
// encodings used by the ID and EX stages.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  // alt selects SUB/SRA (instr[30]); callers mask it where it has no meaning.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: I/S/B/U/J formats, sign-extended to 32 bits.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with load-use stall, flush and ID/EX pipeline register.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data to the operand reads.
module id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        id_ready,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [2:0]  ex_funct3,
  output alu_op_e     ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        illegal
);

  logic [31:0] instr, imm, rs1_val, rs2_val;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  imm_type_e   imm_type;
  alu_op_e     alu_op;
  logic        legal, alu_src, mem_read, mem_write, reg_write, branch, jump;
  logic        rs1_used, rs2_used, load_use, bubble;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  assign instr  = (if_valid && !flush) ? if_instr : NOP_INSTR;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path holds a stale value (no latch).
    legal     = 1'b1;
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    alu_src   = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    case (opcode)
      OPC_LUI:    begin imm_type = IMM_U; alu_op = ALU_COPY_B; reg_write = 1'b1; end
      OPC_AUIPC:  begin imm_type = IMM_U; reg_write = 1'b1; end
      OPC_JAL:    begin imm_type = IMM_J; alu_src = 1'b0; jump = 1'b1; reg_write = 1'b1; end
      OPC_JALR:   begin jump = 1'b1; reg_write = 1'b1; rs1_used = 1'b1; end
      OPC_BRANCH: begin
        imm_type = IMM_B; alu_op = ALU_SUB; alu_src = 1'b0; branch = 1'b1;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_LOAD:   begin mem_read = 1'b1; reg_write = 1'b1; rs1_used = 1'b1; end
      OPC_STORE:  begin imm_type = IMM_S; mem_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      // Only SRAI uses instr[30]; for ADDI it is part of the immediate.
      OPC_OP_IMM: begin
        alu_op = alu_from_funct3(funct3, (funct3 == 3'd5) && instr[30]);
        reg_write = 1'b1; rs1_used = 1'b1;
      end
      OPC_OP:     begin
        alu_op = alu_from_funct3(funct3, instr[30]); alu_src = 1'b0;
        reg_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      default:    legal = 1'b0;
    endcase
  end

  imm_gen u_imm_gen (
    .instr    (instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  always_comb begin
    rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs1_addr) rs1_val = wb_data;
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs2_addr) rs2_val = wb_data;
`endif
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};
`endif

  // The bubble inserted here clears ex_valid, so the stall cannot repeat on the next cycle.
  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && if_valid &&
                    ((rs1_used && ex_rd == rs1_addr) || (rs2_used && ex_rd == rs2_addr));
  assign id_ready = rst || flush || !load_use;
  assign bubble   = flush || !if_valid || load_use || !legal;

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_funct3    <= '0;
      ex_alu_op    <= ALU_ADD;
      ex_alu_src   <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      ex_valid     <= !bubble;
      ex_pc        <= if_pc;
      ex_rs1_val   <= rs1_val;
      ex_rs2_val   <= rs2_val;
      ex_imm       <= imm;
      ex_rd        <= rd;
      ex_rs1       <= instr[19:15];
      ex_rs2       <= instr[24:20];
      ex_funct3    <= funct3;
      ex_alu_op    <= alu_op;
      ex_alu_src   <= alu_src;
      ex_mem_read  <= !bubble && mem_read;
      ex_mem_write <= !bubble && mem_write;
      ex_reg_write <= !bubble && reg_write && (rd != 5'd0);
      ex_branch    <= !bubble && branch;
      ex_jump      <= !bubble && jump;
      illegal      <= if_valid && !flush && !legal;
    end
  end

endmodule
